// File: rtl/axil_dmem_slave.sv
// AXI4-Lite responder backed by a MEM_WORDS x 32 word array.
// Independent write (AW/W hold + response) and read FSMs run concurrently.
module axil_dmem_slave #(
    parameter int unsigned AXI_AWIDTH = 32,
    parameter int unsigned AXI_DWIDTH = 32,
    parameter int unsigned MEM_WORDS  = 1024
) (
    input  logic                    CLK,
    input  logic                    NRST,
    input  logic [AXI_AWIDTH-1:0]   S_AXI_AWADDR,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [AXI_DWIDTH-1:0]   S_AXI_WDATA,
    input  logic [AXI_DWIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [AXI_AWIDTH-1:0]   S_AXI_ARADDR,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [AXI_DWIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY
);

    localparam int unsigned IdxW  = $clog2(MEM_WORDS);
    localparam int unsigned StrbW = AXI_DWIDTH / 8;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    localparam logic WrIdle = 1'b0;
    localparam logic WrResp = 1'b1;
    localparam logic RdIdle = 1'b0;
    localparam logic RdResp = 1'b1;

    logic [AXI_DWIDTH-1:0] mem_q [MEM_WORDS];

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic                  wr_state_q, wr_state_d;
    logic                  aw_held_q, aw_held_d;
    logic [AXI_AWIDTH-1:0] awaddr_q, awaddr_d;
    logic                  w_held_q, w_held_d;
    logic [AXI_DWIDTH-1:0] wdata_q, wdata_d;
    logic [StrbW-1:0]      wstrb_q, wstrb_d;
    logic [1:0]            bresp_q, bresp_d;

    logic                  aw_hs, w_hs, wr_commit, wr_in_range;
    logic [AXI_AWIDTH-1:0] wr_addr;
    logic [AXI_DWIDTH-1:0] wr_data;
    logic [StrbW-1:0]      wr_strb;
    logic [IdxW-1:0]       wr_idx;

    assign S_AXI_AWREADY = (wr_state_q == WrIdle) && !aw_held_q;
    assign S_AXI_WREADY  = (wr_state_q == WrIdle) && !w_held_q;
    assign S_AXI_BVALID  = (wr_state_q == WrResp);
    assign S_AXI_BRESP   = bresp_q;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;

    // A beat arriving this cycle is used directly so AW+W in one cycle commits at once.
    assign wr_addr = aw_held_q ? awaddr_q : S_AXI_AWADDR;
    assign wr_data = w_held_q ? wdata_q : S_AXI_WDATA;
    assign wr_strb = w_held_q ? wstrb_q : S_AXI_WSTRB;

    assign wr_commit   = (wr_state_q == WrIdle) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign wr_in_range = (wr_addr >> (IdxW + 2)) == '0;
    assign wr_idx      = wr_addr[IdxW+1:2];

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        awaddr_d   = awaddr_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            WrIdle: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = S_AXI_AWADDR;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = S_AXI_WDATA;
                    wstrb_d  = S_AXI_WSTRB;
                end
                if (wr_commit) begin
                    wr_state_d = WrResp;
                    bresp_d    = wr_in_range ? RespOkay : RespSlverr;
                end
            end
            WrResp: begin
                if (S_AXI_BREADY) begin
                    wr_state_d = WrIdle;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                end
            end
            default: wr_state_d = WrIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            wr_state_q <= WrIdle;
            aw_held_q  <= 1'b0;
            awaddr_q   <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RespOkay;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            awaddr_q   <= awaddr_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
        end
    end

    // Array has no reset; NRST gating keeps a reset edge from committing a write.
    always_ff @(posedge CLK) begin
        if (wr_commit && wr_in_range && NRST) begin
            for (int b = 0; b < StrbW; b++) begin
                if (wr_strb[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic                  rd_state_q, rd_state_d;
    logic [AXI_DWIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  ar_hs, rd_in_range;
    logic [IdxW-1:0]       rd_idx;

    assign S_AXI_ARREADY = (rd_state_q == RdIdle);
    assign S_AXI_RVALID  = (rd_state_q == RdResp);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    assign ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;
    assign rd_in_range = (S_AXI_ARADDR >> (IdxW + 2)) == '0;
    assign rd_idx      = S_AXI_ARADDR[IdxW+1:2];

    // Array sampled before this edge's write lands, so a colliding read sees old data.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RdIdle: begin
                if (ar_hs) begin
                    rd_state_d = RdResp;
                    rdata_d    = rd_in_range ? mem_q[rd_idx] : '0;
                    rresp_d    = rd_in_range ? RespOkay : RespSlverr;
                end
            end
            RdResp: begin
                if (S_AXI_RREADY) begin
                    rd_state_d = RdIdle;
                end
            end
            default: rd_state_d = RdIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            rd_state_q <= RdIdle;
            rdata_q    <= '0;
            rresp_q    <= RespOkay;
        end else begin
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

endmodule

// File: tb/tb_axil_dmem_slave.sv
// Self-checking bench for axil_dmem_slave: directed vector table, hand-written
// corner sequences, and a randomized phase against a word-array reference model.
module tb_axil_dmem_slave;

    logic        CLK = 1'b0;
    logic        NRST = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    axil_dmem_slave #(
        .AXI_AWIDTH(32),
        .AXI_DWIDTH(32),
        .MEM_WORDS (1024)
    ) dut (
        .CLK          (CLK),
        .NRST         (NRST),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // AW and W presented together; BREADY high. Returns BRESP.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done = 0;
        int n = 0;
        @(negedge CLK);
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        bready = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            @(negedge CLK);
            if (aw_done) awvalid = 1'b0;
            if (w_done) wvalid = 1'b0;
            n++;
        end
        if (!(aw_done && w_done)) check("aw_w_handshake_timeout", 0, 1);
        check("b_latency", bvalid, 1);
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge CLK);
            n++;
        end
        resp = bresp;
        @(posedge CLK);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
        int n = 0;
        @(negedge CLK);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        while (!arready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        arvalid = 1'b0;
        check("r_latency", rvalid, 1);
        data = rdata;
        resp = rresp;
        @(posedge CLK);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] raddr;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_bresp;
        logic [1:0]  exp_rresp;
    } vec_t;

    vec_t        vecs [11];
    logic [31:0] model [16];

    initial begin
        logic [1:0]  resp;
        logic [1:0]  rr;
        logic [31:0] rd;
        logic [31:0] hold_data;

        vecs[0]  = '{32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 32'hCAFE_F00D, 2'b00, 2'b00};
        vecs[1]  = '{32'h0000_0010, 32'hA5A5_A5A5, 4'hF, 32'h0000_0010, 32'hA5A5_A5A5, 2'b00, 2'b00};
        vecs[2]  = '{32'h0000_0030, 32'hFFFF_FFFF, 4'hF, 32'h0000_0030, 32'hFFFF_FFFF, 2'b00, 2'b00};
        vecs[3]  = '{32'h0000_0030, 32'h0000_0000, 4'h5, 32'h0000_0030, 32'hFF00_FF00, 2'b00, 2'b00};
        vecs[4]  = '{32'h0000_0010, 32'h1234_5678, 4'h0, 32'h0000_0010, 32'hA5A5_A5A5, 2'b00, 2'b00};
        vecs[5]  = '{32'h0000_1000, 32'h5555_5555, 4'hF, 32'h0000_1000, 32'h0000_0000, 2'b10, 2'b10};
        vecs[6]  = '{32'h0000_2000, 32'h7777_7777, 4'hF, 32'h0000_0000, 32'hCAFE_F00D, 2'b10, 2'b00};
        vecs[7]  = '{32'h0000_0013, 32'hDEAD_BEEF, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 2'b00, 2'b00};
        vecs[8]  = '{32'h0000_0FFC, 32'h0BAD_C0DE, 4'hF, 32'h0000_0FFC, 32'h0BAD_C0DE, 2'b00, 2'b00};
        vecs[9]  = '{32'h0000_0FFC, 32'h1122_3344, 4'h8, 32'h0000_0FFE, 32'h11AD_C0DE, 2'b00, 2'b00};
        vecs[10] = '{32'hFFFF_FFFC, 32'h9999_9999, 4'hF, 32'hFFFF_FFFC, 32'h0000_0000, 2'b10, 2'b10};

        // Reset state
        #12;
        check("reset_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata},
              {3'b111, 2'b00, 2'b00, 2'b00, 32'h0});
        @(negedge CLK);
        NRST = 1'b1;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            do_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, resp);
            check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_bresp);
            do_read(vecs[i].raddr, rd, rr);
            check($sformatf("vec%0d_rresp", i), rr, vecs[i].exp_rresp);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        end

        // W presented three cycles before AW
        @(negedge CLK);
        wdata = 32'h1122_3344; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        @(negedge CLK);
        wvalid = 1'b0;
        repeat (3) begin
            check("w_early_hold", {wready, bvalid, awready}, 3'b001);
            @(negedge CLK);
        end
        awaddr = 32'h20; awvalid = 1'b1;
        @(negedge CLK);
        awvalid = 1'b0;
        check("w_early_bvalid", {bvalid, bresp}, 3'b100);
        @(posedge CLK);
        do_read(32'h20, rd, rr);
        check("w_early_readback", rd, 32'h1122_3344);

        // Write response back-pressure
        @(negedge CLK);
        awaddr = 32'h40; awvalid = 1'b1; wdata = 32'h600D_0001; wstrb = 4'hF; wvalid = 1'b1;
        bready = 1'b0;
        @(negedge CLK);
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (5) begin
            check("b_stall", {bvalid, bresp, awready, wready}, 5'b10000);
            @(negedge CLK);
        end
        bready = 1'b1;
        @(negedge CLK);
        check("b_release", bvalid, 0);

        // Read response back-pressure
        araddr = 32'h40; arvalid = 1'b1; rready = 1'b0;
        @(negedge CLK);
        arvalid = 1'b0;
        repeat (5) begin
            check("r_stall", {rvalid, rresp, arready, rdata}, {1'b1, 2'b00, 1'b0, 32'h600D_0001});
            @(negedge CLK);
        end
        rready = 1'b1;
        @(negedge CLK);
        check("r_release", rvalid, 0);

        // Read colliding with a write commit on the same word sees the old data
        awaddr = 32'h40; awvalid = 1'b1; wdata = 32'h600D_0002; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 32'h40; arvalid = 1'b1;
        @(negedge CLK);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("collide_valids", {bvalid, rvalid}, 2'b11);
        check("collide_old_data", rdata, 32'h600D_0001);
        @(posedge CLK);
        do_read(32'h40, rd, rr);
        check("collide_new_data", rd, 32'h600D_0002);

        // Reset while an AW is held
        do_write(32'h50, 32'h5A5A_0050, 4'hF, resp);
        @(negedge CLK);
        awaddr = 32'h50; awvalid = 1'b1; wdata = 32'hBAD0_BAD0;
        @(negedge CLK);
        awvalid = 1'b0;
        check("aw_held_before_reset", {awready, wready}, 2'b01);
        NRST = 1'b0;
        #1;
        check("in_reset_outputs", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
        @(negedge CLK);
        NRST = 1'b1;
        @(negedge CLK);
        check("after_reset_outputs", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
        do_read(32'h50, rd, rr);
        check("reset_no_commit", rd, 32'h5A5A_0050);

        // Randomized phase against the word-array model (words 0x100..0x13C)
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom();
            do_write(32'h100 + 32'(i) * 4, model[i], 4'hF, resp);
            check("rnd_init_bresp", resp, 2'b00);
        end
        for (int k = 0; k < 40; k++) begin
            logic [31:0] addr;
            logic [31:0] hi;
            logic [31:0] d;
            logic [3:0]  s;
            int          idx;
            idx = $urandom_range(0, 15);
            addr = 32'h100 + 32'(idx) * 4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                hi = $urandom() & 32'hFFFF_F000;
                if (hi == 0) hi = 32'h1000;
                addr = addr | hi;
            end
            d = $urandom();
            s = 4'($urandom_range(0, 15));
            do_write(addr, d, s, resp);
            if (addr < 32'h1000) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
                check("rnd_bresp", resp, 2'b00);
            end else begin
                check("rnd_bresp", resp, 2'b10);
            end

            idx = $urandom_range(0, 15);
            addr = 32'h100 + 32'(idx) * 4;
            if ($urandom_range(0, 4) == 0) addr = addr | 32'h0010_0000;
            do_read(addr, rd, rr);
            hold_data = (addr < 32'h1000) ? model[idx] : 32'h0;
            check("rnd_rresp", rr, (addr < 32'h1000) ? 2'b00 : 2'b10);
            check("rnd_rdata", rd, hold_data);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
